layer4_weight_streamer: RTL and testbench
=========================================

Name: layer4_weight_streamer

Overview:
- Weight-side transmitter for a residual basic block.
- On a start pulse, fetches three contiguous weight segments from an external read-only weight memory and replays them, in order, as the three valid-qualified weight streams consumed by the block's conv1, conv2 and projection conv.
- Sits between the weight memory controller and the basic block's weight_in1/2/3 ports.

Parameters:
- DATA_WIDTH, 32, weight word width.
- ADDR_WIDTH, 32, memory word-address width.
- WEIGHT_NUM1, 131072, words in segment 1 (256x512x1).
- WEIGHT_NUM2, 2359296, words in segment 2 (512x512x9).
- WEIGHT_NUM3, 131072, words in segment 3 (256x512x1).
- BASE1, 0, word address of segment 1.
- BASE2, 131072, word address of segment 2.
- BASE3, 2490368, word address of segment 3.
- MAX_OUTSTANDING, 8, accepted-but-unreturned read limit (power of 2, >=1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a stream.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last word is emitted.
- mem_req  out  1  read request.
- mem_addr  out  ADDR_WIDTH  request word address.
- mem_ack  in  1  request accepted this cycle when mem_req=1.
- mem_rvalid  in  1  read data valid; responses return in request order, arbitrary latency.
- mem_rdata  in  DATA_WIDTH  read data.
- valid_weight_out1/2/3  out  1 each  stream k word valid.
- weight_out1/2/3  out  DATA_WIDTH each  stream k word.

Behaviour:
- Reset (reset=0, async): FSM=IDLE; all counters 0; busy, done, mem_req, valid_weight_out1..3 = 0; mem_addr, weight_out1..3 = 0.
- TOTAL = WEIGHT_NUM1 + WEIGHT_NUM2 + WEIGHT_NUM3. All counters are wide enough for TOTAL; no wrap.
- IDLE:
  - start=1 -> FETCH.
  - Clear req_cnt, rsp_cnt and outstanding.
  - busy=1 from the next cycle.
- FETCH:
  - mem_req=1 while req_cnt<TOTAL and outstanding<MAX_OUTSTANDING.
  - mem_addr = BASE1+req_cnt for req_cnt<WEIGHT_NUM1.
  - mem_addr = BASE2+(req_cnt-WEIGHT_NUM1) for the next WEIGHT_NUM2 requests.
  - mem_addr = BASE3+(req_cnt-WEIGHT_NUM1-WEIGHT_NUM2) otherwise.
  - mem_req and mem_addr are registered and held stable until mem_ack. On mem_ack, req_cnt++, and the next request may be presented the following cycle, giving 1 request/cycle throughput.
  - When the last request is acked -> DRAIN.
- Outstanding tracking:
  - outstanding += ack, -= rvalid.
  - Simultaneous ack and rvalid leave it unchanged.
  - Never exceeds MAX_OUTSTANDING; an ack cannot occur at the limit because mem_req is low.
- Response routing (FETCH and DRAIN):
  - On mem_rvalid, rsp_cnt selects the destination stream by the same segment boundaries as addressing.
  - The selected weight_outk <= mem_rdata and valid_weight_outk <= 1 for one cycle. Latency is 1 cycle from mem_rvalid.
  - At most one valid_weight_outk is high per cycle. Unselected weight_out registers hold their values.
  - rsp_cnt++.
- DRAIN: when the response with rsp_cnt=TOTAL-1 is taken -> DONE.
- DONE:
  - done=1 is asserted in the same cycle as the final valid_weight_out3.
  - busy=0 from the next cycle; -> IDLE.
- start while busy (FETCH/DRAIN/DONE): ignored.
- mem_rvalid in IDLE: ignored, no output valid.
- Segment boundaries:
  - The first segment-2 response asserts valid_weight_out2, never out1.
  - A zero-size segment is skipped: no valids on that stream, addresses continue from the next segment.
- No backpressure from the weight consumers: the stream rate equals the memory return rate.
- Reset asserted mid-operation: outputs clear immediately and the FSM returns to IDLE. In-flight responses arriving after reset release are ignored while in IDLE.

Test Plan:
- Setup for all scenarios: WEIGHT_NUM1=4, WEIGHT_NUM2=9, WEIGHT_NUM3=2, BASE1=0x100, BASE2=0x200, BASE3=0x300, MAX_OUTSTANDING=4.
- Memory acks every cycle with 3-cycle latency and rdata=addr; pulse start -> addresses 0x100-0x103, 0x200-0x208, 0x300-0x301. Required: 4 words on out1 with values 0x100..0x103, 9 on out2, 2 on out3; done pulses once, coincident with out3 data 0x301; busy high throughout.
- mem_ack withheld for 5 cycles on the 2nd request -> mem_req and mem_addr=0x101 held stable; no duplicate or skipped address.
- Response latency 20 cycles -> mem_req drops after 4 outstanding requests and resumes on the first rvalid; outstanding never exceeds 4; ordering preserved.
- start pulsed in the middle of a stream and again during DONE -> ignored; exactly 15 output valids total.
- reset low during segment 2, then a fresh start -> all outputs 0 during reset; stale rvalids in IDLE produce nothing; the new run restarts at 0x100 and produces the full 15-word sequence.
- WEIGHT_NUM2=0 -> out2 never valid; addresses go 0x103 then 0x300; done after 6 words.

Source files
------------

// File: rtl/layer4_weight_streamer.sv
// Weight-side transmitter for a residual basic block: fetches three contiguous
// weight segments from memory and replays them on the conv1/conv2/projection streams.
module layer4_weight_streamer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned WEIGHT_NUM1 = 131072,
   parameter int unsigned WEIGHT_NUM2 = 2359296,
   parameter int unsigned WEIGHT_NUM3 = 131072,
   parameter logic [ADDR_WIDTH-1:0] BASE1 = 'd0,
   parameter logic [ADDR_WIDTH-1:0] BASE2 = 'd131072,
   parameter logic [ADDR_WIDTH-1:0] BASE3 = 'd2490368,
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  valid_weight_out1,
   output logic                  valid_weight_out2,
   output logic                  valid_weight_out3,
   output logic [DATA_WIDTH-1:0] weight_out1,
   output logic [DATA_WIDTH-1:0] weight_out2,
   output logic [DATA_WIDTH-1:0] weight_out3
);

   localparam int unsigned TOTAL = WEIGHT_NUM1 + WEIGHT_NUM2 + WEIGHT_NUM3;
   localparam int unsigned CNT_W = $clog2(TOTAL + 1);
   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] END1    = CNT_W'(WEIGHT_NUM1);
   localparam logic [CNT_W-1:0] END2    = CNT_W'(WEIGHT_NUM1 + WEIGHT_NUM2);
   localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);
   localparam logic [OUT_W-1:0] MAX_C   = OUT_W'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] req_cnt;
   logic [CNT_W-1:0] rsp_cnt;
   logic [OUT_W-1:0] outstanding;

   logic             ack;
   logic             take;
   logic             dec;
   logic [CNT_W-1:0] req_nxt;
   logic [OUT_W-1:0] out_nxt;

   // Segment index of a word position; empty segments fall through naturally.
   function automatic logic [1:0] seg_of(input logic [CNT_W-1:0] cnt);
      if (cnt < END1)      return 2'd1;
      else if (cnt < END2) return 2'd2;
      else                 return 2'd3;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [CNT_W-1:0] cnt);
      case (seg_of(cnt))
         2'd1:    return BASE1 + ADDR_WIDTH'(cnt);
         2'd2:    return BASE2 + ADDR_WIDTH'(cnt - END1);
         default: return BASE3 + ADDR_WIDTH'(cnt - END2);
      endcase
   endfunction

   always_comb begin
      ack     = mem_req & mem_ack;
      take    = mem_rvalid & ((state == FETCH) | (state == DRAIN));
      dec     = take & (outstanding != '0);
      req_nxt = req_cnt + CNT_W'(ack);
      out_nxt = outstanding + OUT_W'(ack) - OUT_W'(dec);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         req_cnt           <= '0;
         rsp_cnt           <= '0;
         outstanding       <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
         mem_req           <= 1'b0;
         mem_addr          <= '0;
         valid_weight_out1 <= 1'b0;
         valid_weight_out2 <= 1'b0;
         valid_weight_out3 <= 1'b0;
         weight_out1       <= '0;
         weight_out2       <= '0;
         weight_out3       <= '0;
      end else begin
         done              <= 1'b0;
         valid_weight_out1 <= 1'b0;
         valid_weight_out2 <= 1'b0;
         valid_weight_out3 <= 1'b0;

         // Returned words are routed by their position in the overall sequence.
         if (take) begin
            case (seg_of(rsp_cnt))
               2'd1: begin
                  weight_out1       <= mem_rdata;
                  valid_weight_out1 <= 1'b1;
               end
               2'd2: begin
                  weight_out2       <= mem_rdata;
                  valid_weight_out2 <= 1'b1;
               end
               default: begin
                  weight_out3       <= mem_rdata;
                  valid_weight_out3 <= 1'b1;
               end
            endcase
            rsp_cnt <= rsp_cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state       <= FETCH;
                  busy        <= 1'b1;
                  req_cnt     <= '0;
                  rsp_cnt     <= '0;
                  outstanding <= '0;
                  mem_req     <= 1'b1;
                  mem_addr    <= addr_of('0);
               end
            end
            FETCH: begin
               req_cnt     <= req_nxt;
               outstanding <= out_nxt;
               // Request is recomputed from next-cycle counts so an unacked one stays put.
               mem_req     <= (req_nxt < TOTAL_C) && (out_nxt < MAX_C);
               if (req_nxt < TOTAL_C) mem_addr <= addr_of(req_nxt);
               if (take && (rsp_cnt == LAST_C)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (req_nxt == TOTAL_C) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               outstanding <= out_nxt;
               if (take && (rsp_cnt == LAST_C)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_layer4_weight_streamer.sv
// Scoreboard bench for layer4_weight_streamer: a main instance (4/9/2 words)
// and a second instance with an empty middle segment (4/0/2 words).
module tb_layer4_weight_streamer;

   localparam int N1 = 4;
   localparam int N2 = 9;
   localparam int N3 = 2;
   localparam int MAXO = 4;

   typedef struct packed {
      int          stream;
      logic [31:0] data;
      logic        last;
   } exp_t;

   typedef struct packed {
      int          due;
      int          epoch;
      logic [31:0] data;
   } pend_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic        start = 1'b0, busy, done, mem_req, mem_ack = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_addr, mem_rdata = '0, w1, w2, w3;
   logic        v1, v2, v3;

   // empty-segment instance
   logic        b_start = 1'b0, b_busy, b_done, b_req, b_ack = 1'b0, b_rvalid = 1'b0;
   logic [31:0] b_addr, b_rdata = '0, bw1, bw2, bw3;
   logic        bv1, bv2, bv3;

   layer4_weight_streamer #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32),
      .WEIGHT_NUM1(N1), .WEIGHT_NUM2(N2), .WEIGHT_NUM3(N3),
      .BASE1(32'h100), .BASE2(32'h200), .BASE3(32'h300), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .reset(rst_n), .start(start), .busy(busy), .done(done),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .valid_weight_out1(v1), .valid_weight_out2(v2), .valid_weight_out3(v3),
      .weight_out1(w1), .weight_out2(w2), .weight_out3(w3)
   );

   layer4_weight_streamer #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32),
      .WEIGHT_NUM1(N1), .WEIGHT_NUM2(0), .WEIGHT_NUM3(N3),
      .BASE1(32'h100), .BASE2(32'h200), .BASE3(32'h300), .MAX_OUTSTANDING(MAXO)
   ) dut_b (
      .clk(clk), .reset(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
      .mem_req(b_req), .mem_addr(b_addr), .mem_ack(b_ack),
      .mem_rvalid(b_rvalid), .mem_rdata(b_rdata),
      .valid_weight_out1(bv1), .valid_weight_out2(bv2), .valid_weight_out3(bv3),
      .weight_out1(bw1), .weight_out2(bw2), .weight_out3(bw3)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   exp_t    exp_q[$];
   exp_t    b_exp_q[$];
   logic [31:0] addr_q[$];
   logic [31:0] b_addr_q[$];

   task automatic push_run(input bit is_b);
      exp_t e;
      int   n;
      for (int s = 1; s <= 3; s++) begin
         n = (s == 1) ? N1 : (s == 2) ? (is_b ? 0 : N2) : N3;
         for (int i = 0; i < n; i++) begin
            e.stream = s;
            e.data   = 32'h100 * s + i;
            e.last   = (s == 3) && (i == N3 - 1);
            if (is_b) begin
               b_exp_q.push_back(e);
               b_addr_q.push_back(e.data);
            end else begin
               exp_q.push_back(e);
               addr_q.push_back(e.data);
            end
         end
      end
   endtask

   // memory model for the main instance
   int    cyc = 0;
   int    lat = 3;
   int    epoch = 0;
   int    stall_idx = -1;
   int    stall_left = 0;
   int    n_acked = 0;
   int    out_cnt = 0;
   bit    acc_d = 0, rv_live_d = 0, stall_d = 0;
   logic [31:0] addr_d = '0;
   pend_t pend[$];

   always @(negedge clk) begin
      pend_t p;
      cyc++;
      if (!rst_n) begin
         out_cnt = 0;
         acc_d = 0;
         rv_live_d = 0;
         stall_d = 0;
      end else begin
         out_cnt = out_cnt + int'(acc_d) - int'(rv_live_d);
         check("outstanding_le_max", 64'(out_cnt > MAXO), 0);
         if (out_cnt == MAXO) check("req_gated_at_limit", mem_req, 0);
         if (stall_d) begin
            check("req_held", mem_req, 1);
            check("addr_held", mem_addr, addr_d);
         end
      end
      mem_rvalid = 1'b0;
      rv_live_d = 0;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
         p = pend.pop_front();
         mem_rvalid = 1'b1;
         mem_rdata = p.data;
         rv_live_d = (p.epoch == epoch);
      end
      mem_ack = 1'b0;
      acc_d = 0;
      stall_d = 0;
      if (rst_n && mem_req) begin
         if (n_acked == stall_idx && stall_left > 0) begin
            stall_left--;
            stall_d = 1;
            addr_d = mem_addr;
         end else begin
            mem_ack = 1'b1;
            acc_d = 1;
            n_acked++;
            pend.push_back('{due: cyc + lat, epoch: epoch, data: mem_addr});
            if (addr_q.size() == 0) check("unexpected_req", mem_addr, 0);
            else check("req_addr", mem_addr, addr_q.pop_front());
         end
      end
   end

   // output monitor for the main instance
   int n_valid = 0;
   always @(negedge clk) begin
      exp_t        e;
      int          nv, st;
      logic [31:0] d;
      if (!rst_n) begin
         check("rst_ctrl_clear", {busy, done, mem_req, v1, v2, v3}, 0);
         check("rst_data_clear", {mem_addr | w1 | w2 | w3}, 0);
      end else begin
         nv = int'(v1) + int'(v2) + int'(v3);
         if (nv > 1) check("one_valid_per_cycle", nv, 1);
         if (nv != 0) begin
            n_valid++;
            st = v1 ? 1 : v2 ? 2 : 3;
            d  = v1 ? w1 : v2 ? w2 : w3;
            if (exp_q.size() == 0) begin
               check("unexpected_valid", nv, 0);
            end else begin
               e = exp_q.pop_front();
               check("stream_sel", st, e.stream);
               check("stream_data", d, e.data);
               check("done_align", done, e.last);
               check("busy_during", busy, 1);
            end
         end else if (done) begin
            check("done_without_data", done, 0);
         end
      end
   end

   // memory model and monitor for the empty-segment instance
   pend_t b_pend[$];
   int    b_valid = 0;
   always @(negedge clk) begin
      pend_t p;
      exp_t  e;
      int    st;
      b_rvalid = 1'b0;
      if (b_pend.size() != 0 && b_pend[0].due <= cyc) begin
         p = b_pend.pop_front();
         b_rvalid = 1'b1;
         b_rdata = p.data;
      end
      b_ack = 1'b0;
      if (rst_n && b_req) begin
         b_ack = 1'b1;
         b_pend.push_back('{due: cyc + 2, epoch: epoch, data: b_addr});
         if (b_addr_q.size() == 0) check("b_unexpected_req", b_addr, 0);
         else check("b_req_addr", b_addr, b_addr_q.pop_front());
      end
      if (rst_n && (bv1 | bv2 | bv3)) begin
         b_valid++;
         st = bv1 ? 1 : bv2 ? 2 : 3;
         if (b_exp_q.size() == 0) begin
            check("b_unexpected_valid", st, 0);
         end else begin
            e = b_exp_q.pop_front();
            check("b_stream_sel", st, e.stream);
            check("b_stream_data", bv1 ? bw1 : bv2 ? bw2 : bw3, e.data);
            check("b_done_align", b_done, e.last);
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(input bit start_in_done);
      bit seen = 0;
      for (int i = 0; i < 600 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) begin
         check("done_timeout", 0, 1);
      end else begin
         if (start_in_done) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check("busy_clear_after_done", busy, 0);
         check("done_single_pulse", done, 0);
      end
   endtask

   task automatic check_idle(input string tag);
      repeat (10) @(negedge clk);
      check({tag, "_idle_req"}, mem_req, 0);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_exp_empty"}, exp_q.size(), 0);
      check({tag, "_addr_empty"}, addr_q.size(), 0);
   endtask

   initial begin
      int base;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // 1: plain stream, 3-cycle latency
      base = n_valid;
      push_run(0);
      pulse_start();
      wait_done(0);
      check_idle("plain");
      check("plain_count", n_valid - base, 15);

      // 2: ack withheld on second request
      n_acked = 0;
      stall_idx = 1;
      stall_left = 5;
      push_run(0);
      pulse_start();
      wait_done(0);
      check_idle("stall");
      check("stall_consumed", stall_left, 0);
      stall_idx = -1;

      // 3: long latency exercises the outstanding limit
      lat = 20;
      push_run(0);
      pulse_start();
      wait_done(0);
      check_idle("slow");
      lat = 3;

      // 4: start mid-stream and during the done cycle
      base = n_valid;
      push_run(0);
      pulse_start();
      repeat (6) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1);
      check_idle("restart_ignored");
      check("restart_count", n_valid - base, 15);

      // 5: reset during segment 2, stale responses, fresh run
      lat = 5;
      base = n_valid;
      push_run(0);
      pulse_start();
      for (int i = 0; i < 200 && (n_valid - base) < 6; i++) @(negedge clk);
      check("reached_seg2", 64'((n_valid - base) >= 6), 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      epoch++;
      exp_q.delete();
      addr_q.delete();
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      base = n_valid;
      repeat (25) @(negedge clk);
      check("stale_no_valid", n_valid - base, 0);
      check("stale_drained", pend.size(), 0);
      lat = 3;
      push_run(0);
      pulse_start();
      wait_done(0);
      check_idle("after_reset");
      check("after_reset_count", n_valid - base, 15);

      // 6: empty middle segment on the second instance
      base = b_valid;
      push_run(1);
      @(negedge clk);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      check("b_busy_after_start", b_busy, 1);
      for (int i = 0; i < 200 && !b_done; i++) @(negedge clk);
      check("b_done_seen", b_done, 1);
      repeat (10) @(negedge clk);
      check("b_count", b_valid - base, 6);
      check("b_exp_empty", b_exp_q.size(), 0);
      check("b_addr_empty", b_addr_q.size(), 0);
      check("b_busy_clear", b_busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
